tilemap_renderer: RTL and testbench

Parametrised successor to the screen drawer. On a `draw` request it walks a VIEW_W_TILES x VIEW_H_TILES viewport of a scrollable, wrap-around tile map held in map ROM. For each tile it reads the tile index, streams TILE_SIZE x TILE_SIZE pixels from tile ROM, and emits one VGA pixel write per cycle. It sits between the game-state logic (scroll/player position, map base) and the VGA adapter's write port.

---
 rtl/tilemap_renderer.sv | 256 +++++++++++++++++++++++++
 tb/tb_tilemap_renderer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tilemap_renderer.sv
// tilemap_renderer: walks a scrolled, wrap-around viewport of a tile map and streams one VGA pixel per cycle.
// Optional feature macro TRANSPARENT_KEY_EN: pixels whose colour equals KEY_COLOUR are not written.
module tilemap_renderer #(
    parameter int unsigned TILE_SIZE    = 8,
    parameter int unsigned VIEW_W_TILES = 20,
    parameter int unsigned VIEW_H_TILES = 15,
    parameter int unsigned MAP_W_TILES  = 32,
    parameter int unsigned MAP_H_TILES  = 32,
    parameter int unsigned MAP_ADDR_W   = 12,
    parameter int unsigned TILE_IDX_W   = 8,
    parameter int unsigned COLOUR_W     = 24,
    parameter logic [COLOUR_W-1:0] KEY_COLOUR = COLOUR_W'(24'hFF00FF)
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       draw,
    input  logic [$clog2(MAP_W_TILES)-1:0]             scroll_x_volitile,
    input  logic [$clog2(MAP_H_TILES)-1:0]             scroll_y_volitile,
    input  logic [MAP_ADDR_W-1:0]                      map_address_volitile,
    output logic [MAP_ADDR_W-1:0]                      map_rom_address,
    input  logic [TILE_IDX_W-1:0]                      map_rom_data,
    output logic [TILE_IDX_W+2*$clog2(TILE_SIZE)-1:0]  tile_rom_address,
    input  logic [COLOUR_W-1:0]                        tile_rom_data,
    output logic [7:0]                                 vga_x_out_bus,
    output logic [7:0]                                 vga_y_out_bus,
    output logic [COLOUR_W-1:0]                        vga_RGB_out_bus,
    output logic                                       vga_draw_enable_bus,
    output logic                                       active,
    output logic                                       done
);

    localparam int unsigned PX_W = $clog2(TILE_SIZE);
    localparam int unsigned SX_W = $clog2(MAP_W_TILES);
    localparam int unsigned SY_W = $clog2(MAP_H_TILES);
    localparam int unsigned TX_W = (VIEW_W_TILES > 1) ? $clog2(VIEW_W_TILES) : 1;
    localparam int unsigned TY_W = (VIEW_H_TILES > 1) ? $clog2(VIEW_H_TILES) : 1;
    localparam int unsigned TA_W = TILE_IDX_W + 2 * PX_W;
    // Two cycles flush the pixel pipeline, two more form the frame tail before done.
    localparam int unsigned DRAIN_CYCLES = 4;

    localparam logic [PX_W-1:0] PX_LAST = PX_W'(TILE_SIZE - 1);
    localparam logic [TX_W-1:0] TX_LAST = TX_W'(VIEW_W_TILES - 1);
    localparam logic [TY_W-1:0] TY_LAST = TY_W'(VIEW_H_TILES - 1);

`ifdef TRANSPARENT_KEY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_INACTIVE,
        S_LOAD_INIT_VALUES,
        S_REQ_MAP,
        S_WAIT_MAP,
        S_DRAW_TILE,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [SX_W-1:0]         sx_q, sx_d;
    logic [SY_W-1:0]         sy_q, sy_d;
    logic [MAP_ADDR_W-1:0]   base_q, base_d;
    logic [TX_W-1:0]         tx_q, tx_d;
    logic [TY_W-1:0]         ty_q, ty_d;
    logic [PX_W-1:0]         px_q, px_d;
    logic [PX_W-1:0]         py_q, py_d;
    logic [TILE_IDX_W-1:0]   tile_idx_q, tile_idx_d;
    logic [MAP_ADDR_W-1:0]   map_addr_q, map_addr_d;
    logic [TA_W-1:0]         tile_addr_q, tile_addr_d;
    logic [1:0]              drain_cnt_q, drain_cnt_d;
    logic                    s1_valid_q, s1_valid_d;
    logic [7:0]              s1_x_q, s1_x_d;
    logic [7:0]              s1_y_q, s1_y_d;
    logic [7:0]              vga_x_q, vga_x_d;
    logic [7:0]              vga_y_q, vga_y_d;
    logic [COLOUR_W-1:0]     vga_rgb_q, vga_rgb_d;
    logic                    vga_en_q, vga_en_d;
    logic                    active_q, active_d;
    logic                    done_q, done_d;
    logic                    write_c;

    // Wrapped map address: row/col sums truncate to the power-of-two map size.
    function automatic logic [MAP_ADDR_W-1:0] map_addr(
        input logic [MAP_ADDR_W-1:0] base,
        input logic [SX_W-1:0]       sx,
        input logic [SY_W-1:0]       sy,
        input logic [TX_W-1:0]       tx,
        input logic [TY_W-1:0]       ty
    );
        logic [SX_W-1:0] col;
        logic [SY_W-1:0] row;
        col = sx + SX_W'(tx);
        row = sy + SY_W'(ty);
        return base + MAP_ADDR_W'({row, col});
    endfunction

    always_comb begin
        state_d     = state_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        base_d      = base_q;
        tx_d        = tx_q;
        ty_d        = ty_q;
        px_d        = px_q;
        py_d        = py_q;
        tile_idx_d  = tile_idx_q;
        map_addr_d  = map_addr_q;
        tile_addr_d = tile_addr_q;
        drain_cnt_d = drain_cnt_q;
        s1_valid_d  = 1'b0;
        s1_x_d      = s1_x_q;
        s1_y_d      = s1_y_q;
        vga_x_d     = vga_x_q;
        vga_y_d     = vga_y_q;
        vga_rgb_d   = vga_rgb_q;
        vga_en_d    = 1'b0;
        write_c     = s1_valid_q && !(KEY_EN && (tile_rom_data == KEY_COLOUR));

        // Second pipeline stage: ROM data for last cycle's address is on tile_rom_data now.
        if (write_c) begin
            vga_en_d  = 1'b1;
            vga_x_d   = s1_x_q;
            vga_y_d   = s1_y_q;
            vga_rgb_d = tile_rom_data;
        end

        case (state_q)
            S_INACTIVE: begin
                if (draw) state_d = S_LOAD_INIT_VALUES;
            end
            S_LOAD_INIT_VALUES: begin
                sx_d       = scroll_x_volitile;
                sy_d       = scroll_y_volitile;
                base_d     = map_address_volitile;
                tx_d       = '0;
                ty_d       = '0;
                px_d       = '0;
                py_d       = '0;
                map_addr_d = map_addr(map_address_volitile, scroll_x_volitile,
                                      scroll_y_volitile, '0, '0);
                state_d    = S_REQ_MAP;
            end
            S_REQ_MAP: begin
                state_d = S_WAIT_MAP;
            end
            S_WAIT_MAP: begin
                tile_idx_d  = map_rom_data;
                px_d        = '0;
                py_d        = '0;
                tile_addr_d = {map_rom_data, PX_W'(0), PX_W'(0)};
                state_d     = S_DRAW_TILE;
            end
            S_DRAW_TILE: begin
                s1_valid_d = 1'b1;
                s1_x_d     = 8'({tx_q, px_q});
                s1_y_d     = 8'({ty_q, py_q});
                px_d       = px_q + PX_W'(1);
                if (px_q == PX_LAST) begin
                    px_d = '0;
                    py_d = py_q + PX_W'(1);
                    if (py_q == PX_LAST) begin
                        py_d = '0;
                        if (tx_q == TX_LAST && ty_q == TY_LAST) begin
                            drain_cnt_d = '0;
                            state_d     = S_DRAIN;
                        end else begin
                            // Row-major tile order, tx fastest.
                            if (tx_q == TX_LAST) begin
                                tx_d = '0;
                                ty_d = ty_q + TY_W'(1);
                            end else begin
                                tx_d = tx_q + TX_W'(1);
                            end
                            map_addr_d = map_addr(base_q, sx_q, sy_q, tx_d, ty_d);
                            state_d    = S_REQ_MAP;
                        end
                    end
                end
                tile_addr_d = {tile_idx_q, py_d, px_d};
            end
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q + 2'd1;
                if (drain_cnt_q == 2'(DRAIN_CYCLES - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_INACTIVE;
            end
            default: begin
                state_d = S_INACTIVE;
            end
        endcase

        active_d = (state_d != S_INACTIVE) && (state_d != S_DONE);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_INACTIVE;
            sx_q        <= '0;
            sy_q        <= '0;
            base_q      <= '0;
            tx_q        <= '0;
            ty_q        <= '0;
            px_q        <= '0;
            py_q        <= '0;
            tile_idx_q  <= '0;
            map_addr_q  <= '0;
            tile_addr_q <= '0;
            drain_cnt_q <= '0;
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            vga_x_q     <= '0;
            vga_y_q     <= '0;
            vga_rgb_q   <= '0;
            vga_en_q    <= 1'b0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            base_q      <= base_d;
            tx_q        <= tx_d;
            ty_q        <= ty_d;
            px_q        <= px_d;
            py_q        <= py_d;
            tile_idx_q  <= tile_idx_d;
            map_addr_q  <= map_addr_d;
            tile_addr_q <= tile_addr_d;
            drain_cnt_q <= drain_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            vga_x_q     <= vga_x_d;
            vga_y_q     <= vga_y_d;
            vga_rgb_q   <= vga_rgb_d;
            vga_en_q    <= vga_en_d;
            active_q    <= active_d;
            done_q      <= done_d;
        end
    end

    assign map_rom_address     = map_addr_q;
    assign tile_rom_address    = tile_addr_q;
    assign vga_x_out_bus       = vga_x_q;
    assign vga_y_out_bus       = vga_y_q;
    assign vga_RGB_out_bus     = vga_rgb_q;
    assign vga_draw_enable_bus = vga_en_q;
    assign active              = active_q;
    assign done                = done_q;

endmodule

// File: tb/tb_tilemap_renderer.sv
// Bench for tilemap_renderer: address probe table, two full frames against a pixel-list model, reset abort.
module tb_tilemap_renderer;

    localparam int TS       = 8;
    localparam int VW       = 20;
    localparam int VH       = 15;
    localparam int MW       = 32;
    localparam int MH       = 32;
    localparam int NTILES   = VW * VH;
    localparam int PIX      = TS * TS;
    localparam int TILE_CYC = PIX + 2;
    localparam logic [23:0] KEY = 24'hFF00FF;

    logic        clk = 1'b0;
    logic        reset, draw;
    logic [4:0]  sx, sy;
    logic [11:0] base;
    logic [11:0] map_rom_address;
    logic [7:0]  map_rom_data;
    logic [13:0] tile_rom_address;
    logic [23:0] tile_rom_data;
    logic [7:0]  vx, vy;
    logic [23:0] vrgb;
    logic        ven, active, done;

    tilemap_renderer dut (
        .clk(clk), .reset(reset), .draw(draw),
        .scroll_x_volitile(sx), .scroll_y_volitile(sy), .map_address_volitile(base),
        .map_rom_address(map_rom_address), .map_rom_data(map_rom_data),
        .tile_rom_address(tile_rom_address), .tile_rom_data(tile_rom_data),
        .vga_x_out_bus(vx), .vga_y_out_bus(vy), .vga_RGB_out_bus(vrgb),
        .vga_draw_enable_bus(ven), .active(active), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM models
    logic [7:0] map_mem [4096];

    function automatic logic [23:0] tile_colour(input logic [13:0] a);
`ifdef TRANSPARENT_KEY_EN
        if (a[2:0] == 3'd0) return KEY;
`endif
        return {10'd0, a};
    endfunction

    always @(posedge clk) begin
        map_rom_data  <= map_mem[map_rom_address];
        tile_rom_data <= tile_colour(tile_rom_address);
    end

    // Cycle counter and output monitor
    typedef struct { int cyc; logic [7:0] x; logic [7:0] y; logic [23:0] rgb; } pix_t;
    typedef struct { logic [7:0] x; logic [7:0] y; logic [23:0] rgb; logic en; } exp_t;

    int   cyc = 0;
    pix_t got_q[$];
    exp_t exp_q[$];
    int   done_q[$];
    int   rise_q[$];
    int   fall_q[$];
    logic active_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        pix_t p;
        if (ven === 1'b1) begin
            p.cyc = cyc; p.x = vx; p.y = vy; p.rgb = vrgb;
            got_q.push_back(p);
        end
        if (done === 1'b1) done_q.push_back(cyc);
        if (active === 1'b1 && active_prev !== 1'b1) rise_q.push_back(cyc);
        if (active !== 1'b1 && active_prev === 1'b1) fall_q.push_back(cyc);
        active_prev = active;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step();
    endtask

    task automatic clear_mon();
        got_q.delete(); done_q.delete(); rise_q.delete(); fall_q.delete();
    endtask

    function automatic pix_t pix_at(input int i);
        pix_t p;
        p.cyc = -1; p.x = '0; p.y = '0; p.rgb = '0;
        if (i >= 0 && i < got_q.size()) p = got_q[i];
        return p;
    endfunction

    // Reference: full ordered pixel list of a frame, straight from the map/tile rules.
    task automatic build_model(input int msx, input int msy, input int mbase);
        exp_q.delete();
        for (int ty = 0; ty < VH; ty++) begin
            for (int tx = 0; tx < VW; tx++) begin
                int addr;
                int idx;
                addr = (mbase + ((msy + ty) % MH) * MW + ((msx + tx) % MW)) % 4096;
                idx  = int'(map_mem[addr]);
                for (int py = 0; py < TS; py++) begin
                    for (int px = 0; px < TS; px++) begin
                        exp_t e;
                        e.x   = 8'((tx * TS + px) % 256);
                        e.y   = 8'((ty * TS + py) % 256);
                        e.rgb = tile_colour(14'(idx * PIX + py * TS + px));
                        e.en  = (e.rgb != KEY);
                        exp_q.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic check_frame(input string tag, input int t_draw);
        int    gi;
        int    n_en;
        int    ec;
        bit    bad;
        string msg;
        int    done_exp;
        pix_t  g;
        gi = 0; n_en = 0; bad = 0; msg = "";
        for (int j = 0; j < exp_q.size(); j++) begin
            if (exp_q[j].en) begin
                n_en++;
                ec = t_draw + 6 + (j / PIX) * TILE_CYC + (j % PIX);
                if (!bad) begin
                    g = pix_at(gi);
                    if (g.cyc != ec || g.x !== exp_q[j].x || g.y !== exp_q[j].y || g.rgb !== exp_q[j].rgb) begin
                        bad = 1;
                        msg = $sformatf("pixel %0d got cyc %0d (%0d,%0d) rgb %h, want cyc %0d (%0d,%0d) rgb %h",
                                        j, g.cyc - t_draw, g.x, g.y, g.rgb, ec - t_draw,
                                        exp_q[j].x, exp_q[j].y, exp_q[j].rgb);
                    end
                end
                gi++;
            end
        end
        n_checks++;
        if (!bad) n_pass++;
        else $display("FAIL %s stream: %s", tag, msg);
        check({tag, " enable_count"}, 32'(got_q.size()), 32'(n_en));
        done_exp = t_draw + 6 + (NTILES - 1) * TILE_CYC + (PIX - 1) + 3;
        check({tag, " done_count"}, 32'(done_q.size()), 32'd1);
        check({tag, " done_cycle"}, 32'(done_q.size() > 0 ? done_q[0] - t_draw : -1), 32'(done_exp - t_draw));
        check({tag, " active_fall"}, 32'(fall_q.size() > 0 ? fall_q[0] - t_draw : -1), 32'(done_exp - t_draw));
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done_q.size() == 0 && n < limit) begin
            step();
            n++;
        end
    endtask

    // Address probes: first three tiles and the first tile of viewport row 1.
    typedef struct {
        logic [4:0]  sx;
        logic [4:0]  sy;
        logic [11:0] base;
        logic [11:0] a0;
        logic [11:0] a1;
        logic [11:0] a2;
        logic [11:0] a20;
    } probe_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        probe_t probes[4];
        int     t;
        int     t_b;
        int     l2;
        int     n;
        pix_t   p;
        pix_t   q;

        probes[0] = '{5'd0,  5'd0,  12'h000, 12'h000, 12'h001, 12'h002, 12'h020};
        probes[1] = '{5'd30, 5'd31, 12'h100, 12'h4FE, 12'h4FF, 12'h4E0, 12'h11E};
        probes[2] = '{5'd31, 5'd0,  12'hFFF, 12'h01E, 12'hFFF, 12'h000, 12'h03E};
        probes[3] = '{5'd5,  5'd31, 12'h800, 12'hBE5, 12'hBE6, 12'hBE7, 12'h805};

        for (int i = 0; i < 4096; i++) map_mem[i] = 8'(i);
        reset = 1'b1; draw = 1'b0; sx = '0; sy = '0; base = '0;
        repeat (3) step();

        check("reset enable",   32'(ven),              32'd0);
        check("reset active",   32'(active),           32'd0);
        check("reset done",     32'(done),             32'd0);
        check("reset map_addr", 32'(map_rom_address),  32'd0);
        check("reset tile_addr",32'(tile_rom_address), 32'd0);
        check("reset xy",       32'({vx, vy}),         32'd0);
        check("reset rgb",      32'(vrgb),             32'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            sx = probes[i].sx; sy = probes[i].sy; base = probes[i].base;
            draw = 1'b1; t = cyc;
            step();
            draw = 1'b0;
            wait_until(t + 2);
            check($sformatf("probe%0d addr tile0", i), 32'(map_rom_address), 32'(probes[i].a0));
            wait_until(t + 6);
            check($sformatf("probe%0d first pixel", i), 32'({ven, vx, vy}), 32'({1'b1, 8'd0, 8'd0}));
            wait_until(t + 2 + TILE_CYC);
            check($sformatf("probe%0d addr tile1", i), 32'(map_rom_address), 32'(probes[i].a1));
            wait_until(t + 2 + 2 * TILE_CYC);
            check($sformatf("probe%0d addr tile2", i), 32'(map_rom_address), 32'(probes[i].a2));
            wait_until(t + 2 + 20 * TILE_CYC);
            check($sformatf("probe%0d addr tile20", i), 32'(map_rom_address), 32'(probes[i].a20));
            reset = 1'b1;
            step();
            check($sformatf("probe%0d abort", i), 32'({ven, active, done}), 32'd0);
            reset = 1'b0;
            step();
        end

        // Frame A: scroll 0, base 0, volatile inputs and draw disturbed mid-frame.
        build_model(0, 0, 0);
        sx = '0; sy = '0; base = '0;
        clear_mon();
        draw = 1'b1; t = cyc;
        step();
        draw = 1'b0;
        wait_until(t + 5000);
        sx = 5'($urandom_range(1, 31)); sy = 5'($urandom_range(1, 31)); base = 12'($urandom_range(1, 4095));
        draw = 1'b1;
        step();
        draw = 1'b0;
        wait_done(21000);
        repeat (50) step();
        check_frame("A", t);
        check("A no second frame", 32'(rise_q.size()), 32'd1);
        p = pix_at(got_q.size() - 1);
        check("A last pixel xy", 32'({p.x, p.y}), 32'({8'd159, 8'd119}));
        check("A done after last enable", 32'(done_q.size() > 0 ? done_q[0] - p.cyc : -1), 32'd3);
`ifndef TRANSPARENT_KEY_EN
        p = pix_at(0);
        check("A first enable cycle", 32'(p.cyc - t), 32'd6);
        check("A first pixel rgb", 32'(p.rgb), 32'd0);
        p = pix_at(63);
        q = pix_at(64);
        check("A tile gap", 32'(q.cyc - p.cyc), 32'd3);
        check("A tile1 x", 32'(q.x), 32'd8);
        check("A tile1 addr", 32'(q.rgb), 32'(1 << 6));
`else
        p = pix_at(0);
        check("A first enable cycle", 32'(p.cyc - t), 32'd7);
        check("A keyed count", 32'(got_q.size()), 32'd16800);
        n = 0;
        foreach (got_q[i]) if (got_q[i].x[2:0] == 3'd0) n++;
        check("A keyed x multiples", 32'(n), 32'd0);
`endif

        // Frame B: random map contents and scroll, draw held high for back-to-back frames.
        for (int i = 0; i < 4096; i++) map_mem[i] = 8'($urandom);
        sx = 5'($urandom_range(0, 31)); sy = 5'($urandom_range(0, 31)); base = 12'($urandom);
        build_model(int'(sx), int'(sy), int'(base));
        clear_mon();
        draw = 1'b1; t_b = cyc;
        wait_done(21000);
        check_frame("B", t_b);
        n = 0;
        while (rise_q.size() < 2 && n < 20) begin
            step();
            n++;
        end
        l2 = (rise_q.size() > 1) ? rise_q[1] : cyc;
        check("B restart after done", 32'(done_q.size() > 0 ? l2 - done_q[0] : -1), 32'd2);
        draw = 1'b0;

        // Abort the second frame mid-tile.
        wait_until(l2 + 999);
        check("B pre-reset enable", 32'(ven), 32'd1);
        reset = 1'b1;
        step();
        check("B reset enable", 32'(ven), 32'd0);
        check("B reset active", 32'(active), 32'd0);
        reset = 1'b0;
        repeat (300) step();
        check("B no done after abort", 32'(done_q.size()), 32'd1);
        check("B no restart after abort", 32'(rise_q.size()), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
